// File: rtl/hdbn_encoder.sv
// HDBn line encoder: AMI marks with zero-run substitution (B..V window of ZMAX+1 symbols),
// strobed input, dual-rail P/N output with valid/substitution markers and a saturating V counter.
module hdbn_encoder #(
  parameter int ZMAX  = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_en,
  input  logic             data,
  input  logic             mode,
  output logic             P,
  output logic             N,
  output logic             out_valid,
  output logic             sub_flag,
  output logic [CNT_W-1:0] viol_cnt
);

  localparam int L  = ZMAX + 1;
  localparam int CW = $clog2(L + 1);
  localparam logic [CW-1:0] L_C = CW'(L);

  typedef enum logic {POL_NEG = 1'b0, POL_POS = 1'b1} pol_t;

  // Symbol encoding: {sub, p, n}; B and V differ only by pipeline position.
  function automatic logic [2:0] mark(input pol_t pol, input logic sub);
    return {sub, pol == POL_POS, pol == POL_NEG};
  endfunction

  function automatic pol_t flip(input pol_t pol);
    return (pol == POL_POS) ? POL_NEG : POL_POS;
  endfunction

  logic [2:0]       r_sym [L];
  pol_t             r_last_pol;
  logic             r_parity;
  logic [CW-1:0]    r_run;
  logic [CW-1:0]    r_prime;
  logic [CNT_W-1:0] r_viol;
  logic             r_p;
  logic             r_n;
  logic             r_valid;
  logic             r_sub;

  logic [2:0]       w_new_sym;
  pol_t             w_next_pol;
  pol_t             w_v_pol;
  logic             w_next_parity;
  logic [CW-1:0]    w_next_run;
  logic             w_sub;
  logic             w_use_b;

  always_comb begin
    w_new_sym     = '0;
    w_next_pol    = r_last_pol;
    w_v_pol       = r_last_pol;
    w_next_parity = r_parity;
    w_next_run    = '0;
    w_sub         = 1'b0;
    if (data) begin
      w_next_pol    = flip(r_last_pol);
      w_new_sym     = mark(w_next_pol, 1'b0);
      w_next_parity = ~r_parity;
    end else if (mode) begin
      w_next_run = r_run + 1'b1;
      if (w_next_run == L_C) begin
        // Even mark count needs a B to keep V alternating; odd count uses V alone.
        w_sub         = 1'b1;
        w_next_run    = '0;
        w_next_parity = 1'b0;
        w_v_pol       = r_parity ? r_last_pol : flip(r_last_pol);
        w_next_pol    = w_v_pol;
        w_new_sym     = mark(w_v_pol, 1'b1);
      end
    end
    w_use_b = w_sub & ~r_parity;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < L; i++) r_sym[i] <= '0;
      r_last_pol <= POL_NEG;
      r_parity   <= 1'b0;
      r_run      <= '0;
      r_prime    <= '0;
      r_viol     <= '0;
      r_p        <= 1'b0;
      r_n        <= 1'b0;
      r_valid    <= 1'b0;
      r_sub      <= 1'b0;
    end else if (bit_en) begin
      r_sub <= r_sym[L-1][2];
      r_p   <= r_sym[L-1][1];
      r_n   <= r_sym[L-1][0];
      if (r_prime == L_C) begin
        r_valid <= 1'b1;
      end else begin
        r_valid <= 1'b0;
        r_prime <= r_prime + 1'b1;
      end
      r_sym[0] <= w_new_sym;
      for (int unsigned i = 1; i < L; i++) r_sym[i] <= r_sym[i-1];
      // The B overrides the zero that is shifting into the oldest slot on this same edge.
      if (w_use_b) r_sym[L-1] <= mark(w_v_pol, 1'b1);
      r_last_pol <= w_next_pol;
      r_parity   <= w_next_parity;
      r_run      <= w_next_run;
      if (w_sub && (r_viol != '1)) r_viol <= r_viol + 1'b1;
    end else begin
      r_valid <= 1'b0;
    end
  end

  assign P         = r_p;
  assign N         = r_n;
  assign out_valid = r_valid;
  assign sub_flag  = r_sub;
  assign viol_cnt  = r_viol;

endmodule

// File: tb/tb_hdbn_encoder.sv
// Directed bench for hdbn_encoder (ZMAX=3): symbol sequences, priming, gaps, reset, saturation.
module tb_hdbn_encoder;

  localparam logic [2:0] SZ = 3'b000;
  localparam logic [2:0] SP = 3'b010;
  localparam logic [2:0] SM = 3'b001;
  localparam logic [2:0] BP = 3'b110;
  localparam logic [2:0] BM = 3'b101;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        bit_en = 1'b0;
  logic        data = 1'b0;
  logic        mode = 1'b1;
  logic        P, N, out_valid, sub_flag;
  logic [15:0] viol_cnt;

  logic        bit_en2 = 1'b0;
  logic        P2, N2, out_valid2, sub_flag2;
  logic [1:0]  viol_cnt2;

  int          total = 0;
  int          bad = 0;
  logic [2:0]  got[$];
  logic        last_v;

  always #5 clk = ~clk;

  hdbn_encoder #(.ZMAX(3), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .bit_en(bit_en), .data(data), .mode(mode),
    .P(P), .N(N), .out_valid(out_valid), .sub_flag(sub_flag), .viol_cnt(viol_cnt)
  );

  hdbn_encoder #(.ZMAX(3), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .bit_en(bit_en2), .data(data), .mode(mode),
    .P(P2), .N(N2), .out_valid(out_valid2), .sub_flag(sub_flag2), .viol_cnt(viol_cnt2)
  );

  task automatic strobe(input logic d, input logic m);
    @(negedge clk);
    bit_en = 1'b1; data = d; mode = m;
    @(posedge clk);
    #1;
    bit_en = 1'b0;
    last_v = out_valid;
    if (out_valid) got.push_back({sub_flag, P, N});
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; bit_en = 1'b0; bit_en2 = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    got.delete();
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++;
    if ({P, N, out_valid, sub_flag} !== 4'b0000) begin
      bad++; $display("FAIL reset_outputs got=%b want=0000", {P, N, out_valid, sub_flag});
    end
    total++;
    if (viol_cnt !== 16'd0) begin
      bad++; $display("FAIL reset_viol got=%0d want=0", viol_cnt);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_marks();
    logic       bits[8] = '{1, 1, 0, 1, 1, 1, 1, 1};
    logic [2:0] exp[4]  = '{SP, SM, SZ, SP};
    logic [2:0] g;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      strobe(bits[i], 1'b1);
      if (i < 5) begin
        total++;
        if (last_v !== (i == 4)) begin
          bad++; $display("FAIL prime_valid strobe=%0d got=%b want=%b", i + 1, last_v, (i == 4));
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      g = (i < got.size()) ? got[i] : 3'bxxx;
      total++;
      if (g !== exp[i]) begin
        bad++; $display("FAIL marks_sym idx=%0d got=%b want=%b", i, g, exp[i]);
      end
    end
    total++;
    if (viol_cnt !== 16'd0) begin
      bad++; $display("FAIL marks_viol got=%0d want=0", viol_cnt);
    end
  endtask

  task automatic test_all_zero();
    logic       bits[8] = '{0, 0, 0, 0, 1, 1, 1, 1};
    logic [2:0] exp[4]  = '{BP, SZ, SZ, BP};
    logic [2:0] g;
    do_reset();
    for (int i = 0; i < 8; i++) strobe(bits[i], 1'b1);
    for (int i = 0; i < 4; i++) begin
      g = (i < got.size()) ? got[i] : 3'bxxx;
      total++;
      if (g !== exp[i]) begin
        bad++; $display("FAIL zero4_sym idx=%0d got=%b want=%b", i, g, exp[i]);
      end
    end
    total++;
    if (viol_cnt !== 16'd1) begin
      bad++; $display("FAIL zero4_viol got=%0d want=1", viol_cnt);
    end
  endtask

  task automatic test_odd_parity();
    logic       bits[10] = '{1, 0, 0, 0, 0, 1, 1, 1, 1, 1};
    logic [2:0] exp[6]   = '{SP, SZ, SZ, SZ, BP, SM};
    logic [2:0] g;
    do_reset();
    for (int i = 0; i < 10; i++) strobe(bits[i], 1'b1);
    for (int i = 0; i < 6; i++) begin
      g = (i < got.size()) ? got[i] : 3'bxxx;
      total++;
      if (g !== exp[i]) begin
        bad++; $display("FAIL odd_sym idx=%0d got=%b want=%b", i, g, exp[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic       bits[18] = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1};
    logic [2:0] exp[14]  = '{SP, SM, BP, SZ, SZ, BP, BM, SZ, SZ, BM, BP, SZ, SZ, BP};
    logic [2:0] g;
    do_reset();
    for (int i = 0; i < 18; i++) strobe(bits[i], 1'b1);
    for (int i = 0; i < 14; i++) begin
      g = (i < got.size()) ? got[i] : 3'bxxx;
      total++;
      if (g !== exp[i]) begin
        bad++; $display("FAIL b2b_sym idx=%0d got=%b want=%b", i, g, exp[i]);
      end
    end
    total++;
    if (viol_cnt !== 16'd3) begin
      bad++; $display("FAIL b2b_viol got=%0d want=3", viol_cnt);
    end
  endtask

  task automatic test_mode();
    logic       bits1[14]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1};
    logic [2:0] exp1[10]   = '{SZ, SZ, SZ, SZ, SZ, SZ, SZ, SZ, SP, SM};
    logic       modes2[12] = '{1, 1, 1, 0, 1, 1, 1, 1, 1, 1, 1, 1};
    logic       bits2[12]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1};
    logic [2:0] exp2[8]    = '{SZ, SZ, SZ, SZ, BP, SZ, SZ, BP};
    logic [2:0] g;
    do_reset();
    for (int i = 0; i < 14; i++) strobe(bits1[i], 1'b0);
    for (int i = 0; i < 10; i++) begin
      g = (i < got.size()) ? got[i] : 3'bxxx;
      total++;
      if (g !== exp1[i]) begin
        bad++; $display("FAIL ami_sym idx=%0d got=%b want=%b", i, g, exp1[i]);
      end
    end
    total++;
    if (viol_cnt !== 16'd0) begin
      bad++; $display("FAIL ami_viol got=%0d want=0", viol_cnt);
    end
    do_reset();
    for (int i = 0; i < 12; i++) strobe(bits2[i], modes2[i]);
    for (int i = 0; i < 8; i++) begin
      g = (i < got.size()) ? got[i] : 3'bxxx;
      total++;
      if (g !== exp2[i]) begin
        bad++; $display("FAIL modesw_sym idx=%0d got=%b want=%b", i, g, exp2[i]);
      end
    end
    total++;
    if (viol_cnt !== 16'd1) begin
      bad++; $display("FAIL modesw_viol got=%0d want=1", viol_cnt);
    end
  endtask

  task automatic test_gap();
    logic bits[5] = '{1, 1, 0, 1, 1};
    do_reset();
    for (int i = 0; i < 5; i++) strobe(bits[i], 1'b1);
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      #1;
      total++;
      if ({out_valid, P, N} !== 3'b010) begin
        bad++; $display("FAIL gap_hold cyc=%0d got=%b want=010", c, {out_valid, P, N});
      end
    end
    strobe(1'b1, 1'b1);
    total++;
    if ({last_v, sub_flag, P, N} !== {1'b1, SM}) begin
      bad++; $display("FAIL gap_resume got=%b want=%b", {last_v, sub_flag, P, N}, {1'b1, SM});
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 5; i++) strobe(1'b0, 1'b1);
    total++;
    if ({out_valid, sub_flag, P, N, viol_cnt} !== {1'b1, BP, 16'd1}) begin
      bad++; $display("FAIL midrst_pre got=%b/%0d want=1110/1", {out_valid, sub_flag, P, N}, viol_cnt);
    end
    #3;
    reset = 1'b0;
    #1;
    total++;
    if ({out_valid, sub_flag, P, N, viol_cnt} !== 20'd0) begin
      bad++; $display("FAIL midrst_clear got=%b/%0d want=0000/0", {out_valid, sub_flag, P, N}, viol_cnt);
    end
    @(negedge clk);
    reset = 1'b1;
    got.delete();
    for (int i = 0; i < 5; i++) begin
      strobe(1'b1, 1'b1);
      total++;
      if (last_v !== (i == 4)) begin
        bad++; $display("FAIL midrst_prime strobe=%0d got=%b want=%b", i + 1, last_v, (i == 4));
      end
    end
    total++;
    if ({sub_flag, P, N} !== SP) begin
      bad++; $display("FAIL midrst_first got=%b want=%b", {sub_flag, P, N}, SP);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      bit_en2 = 1'b1; data = 1'b0; mode = 1'b1;
      @(posedge clk);
      #1;
      bit_en2 = 1'b0;
      if (i == 8) begin
        total++;
        if (viol_cnt2 !== 2'd2) begin
          bad++; $display("FAIL sat_mid got=%0d want=2", viol_cnt2);
        end
      end
    end
    total++;
    if (viol_cnt2 !== 2'd3) begin
      bad++; $display("FAIL sat_end got=%0d want=3", viol_cnt2);
    end
  endtask

  initial begin
    test_reset();
    test_marks();
    test_all_zero();
    test_odd_parity();
    test_back_to_back();
    test_mode();
    test_gap();
    test_reset_mid();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
